eq_spi_rx: RTL and testbench
============================

EQ_SPI_RX -- requirements
Module: eq_spi_rx

Interface
REQ-001 Parameter NBANDS, default 4: number of EQ bands per frame; legal range 1..16.
REQ-002 Parameter BAND_W, default 8: bits per band gain word; legal range 4..16.
REQ-003 Derived FRAME_W = NBANDS*BAND_W bits; the bit counter SHALL be $clog2(FRAME_W+2) bits wide.
REQ-004 clk  in  1  system clock; the block SHALL use this single clock only.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 sck  in  1  SPI serial clock, asynchronous to clk.
REQ-007 sdi  in  1  SPI serial data, MSB first, stable around the rising edge of sck.
REQ-008 ce  in  1  active-high frame enable, asynchronous; high for the whole frame.
REQ-009 eq_vals  out  FRAME_W  last committed frame; band k occupies bits [(k+1)*BAND_W-1 : k*BAND_W].
REQ-010 eq_valid  out  1  one-clk pulse when eq_vals is updated.
REQ-011 frame_err  out  1  one-clk pulse when a frame closes with a bit count other than FRAME_W.
REQ-012 busy  out  1  high while the FSM is in RECV.
REQ-013 frame_cnt  out  8  count of committed frames.

Function
REQ-014 sck, sdi and ce SHALL each pass through an identical 2-flop synchronizer in clk, so all three stay mutually aligned.
REQ-015 A sck rising edge SHALL be detected as synced sck = 1 with the previous synced sck = 0; detection occurs 3 clk cycles after the pin edge.
REQ-016 ce falling and rising edges SHALL be detected the same way from synced ce.
REQ-017 Input timing: sck high and sck low each >= 3 clk periods; ce low between frames >= 3 clk periods.
REQ-018 The FSM SHALL have three states: IDLE, RECV and CLOSE, and SHALL reset to IDLE.
REQ-019 IDLE -> RECV on synced ce = 1; at this transition the bit counter and shift register SHALL clear to 0.
REQ-020 In RECV, each detected sck edge with count < FRAME_W SHALL shift in the synced sdi: shreg <= {shreg[FRAME_W-2:0], sdi}, count += 1.
REQ-021 In RECV, a sck edge with count >= FRAME_W SHALL NOT shift; count SHALL saturate at FRAME_W+1, marking overflow.
REQ-022 RECV -> CLOSE on a ce falling edge; a sck edge detected in the same cycle SHALL be discarded.
REQ-023 In CLOSE, if count == FRAME_W: eq_vals <= shreg, eq_valid = 1 for that cycle, and frame_cnt += 1, wrapping 255 -> 0.
REQ-024 In CLOSE, if count != FRAME_W (short, zero-length or overflow): frame_err = 1 for that cycle; eq_vals and frame_cnt hold.
REQ-025 CLOSE SHALL always last exactly one cycle, then -> IDLE.
REQ-026 First bit received SHALL land in eq_vals MSB, so band NBANDS-1 is transmitted first.
REQ-027 eq_vals SHALL change only in CLOSE on a valid frame; otherwise it holds its value indefinitely.
REQ-028 busy SHALL be registered and equal (state == RECV).
REQ-029 eq_valid and frame_err SHALL never both be high in the same cycle.

Reset
REQ-030 When reset = 1, on the next rising edge of clk: state = IDLE, shreg = 0, count = 0, eq_vals = 0, eq_valid = 0, frame_err = 0, busy = 0, frame_cnt = 0, and all synchronizer flops = 0.
REQ-031 Reset in mid-frame SHALL discard the partial frame with no eq_valid and no frame_err.
REQ-032 After reset releases with ce already high, the block SHALL enter RECV within 3 cycles, and that frame SHALL be received normally.

Verification (NBANDS=4, BAND_W=8)
REQ-033 ce high, 32 bits of 0xA1B2C3D4, ce low -> 3-4 clk later eq_valid pulses once; eq_vals = 0xA1B2C3D4; band3 = 0xA1; band0 = 0xD4; frame_cnt = 1.
REQ-034 After REQ-033, a frame of 31 bits -> frame_err pulses once; eq_vals stays 0xA1B2C3D4; frame_cnt stays 1.
REQ-035 A frame of 33 bits (first 32 = 0x0F0F0F0F) -> frame_err pulses; eq_vals unchanged; a ce pulse with 0 sck edges also -> frame_err.
REQ-036 Reset after 16 bits of a frame -> all outputs 0, no pulse; a following full frame of 0x12345678 -> eq_vals = 0x12345678, frame_cnt = 1.
REQ-037 256 consecutive valid frames -> frame_cnt = 0 with exactly 256 eq_valid pulses; busy high only during each ce window (plus sync delay).
REQ-038 Parameter sweep NBANDS=2/BAND_W=12 with 24 bits of 0xABC123 -> eq_vals = 0xABC123, band1 = 0xABC.

Source files
------------

// File: rtl/eq_spi_rx.sv
// SPI-style receiver for an EQ gain frame: oversamples sck/sdi/ce in clk,
// shifts bits MSB-first while ce is high and commits the frame on ce fall.
module eq_spi_rx #(
   parameter int NBANDS = 4,
   parameter int BAND_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sck,
   input  logic                       sdi,
   input  logic                       ce,
   output logic [NBANDS*BAND_W-1:0]   eq_vals,
   output logic                       eq_valid,
   output logic                       frame_err,
   output logic                       busy,
   output logic [7:0]                 frame_cnt
);
   localparam int FRAME_W = NBANDS * BAND_W;
   localparam int CW      = $clog2(FRAME_W + 2);
   localparam logic [CW-1:0] FULL = CW'(FRAME_W);
   localparam logic [CW-1:0] OVF  = CW'(FRAME_W + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] CLOSE = 2'd2;

   // [0],[1] are the synchronizer; [2] of sck/ce is the previous synced value
   logic [2:0] sck_q, ce_q;
   logic [1:0] sdi_q;
   logic       sck_rise, ce_fall;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [FRAME_W-1:0] shreg_q, shreg_d;
   logic [FRAME_W-1:0] vals_q, vals_d;
   logic [7:0]         fcnt_q, fcnt_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic               busy_q;

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign ce_fall  = ~ce_q[1] & ce_q[2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      vals_d  = vals_q;
      fcnt_d  = fcnt_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ce_q[1]) begin
               state_d = RECV;
               cnt_d   = '0;
               shreg_d = '0;
            end
         end
         RECV: begin
            // ce fall wins over a coincident sck edge
            if (ce_fall) begin
               state_d = CLOSE;
            end else if (sck_rise) begin
               if (cnt_q < FULL) begin
                  shreg_d = {shreg_q[FRAME_W-2:0], sdi_q[1]};
                  cnt_d   = cnt_q + CW'(1);
               end else begin
                  cnt_d = OVF;
               end
            end
         end
         CLOSE: begin
            state_d = IDLE;
            if (cnt_q == FULL) begin
               vals_d  = shreg_q;
               valid_d = 1'b1;
               fcnt_d  = fcnt_q + 8'd1;
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q   <= '0;
         ce_q    <= '0;
         sdi_q   <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         vals_q  <= '0;
         fcnt_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sck_q   <= {sck_q[1:0], sck};
         ce_q    <= {ce_q[1:0], ce};
         sdi_q   <= {sdi_q[0], sdi};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         vals_q  <= vals_d;
         fcnt_q  <= fcnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= (state_d == RECV);
      end
   end

   assign eq_vals   = vals_q;
   assign eq_valid  = valid_q;
   assign frame_err = err_q;
   assign busy      = busy_q;
   assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_eq_spi_rx.sv
// Bench for eq_spi_rx: table vectors, random frames against a frame-level
// model, and hand sequences for reset, overflow and counter wrap.
module tb_eq_spi_rx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sck = 1'b0, sdi = 1'b0, ce = 1'b0;
   logic sck2 = 1'b0, sdi2 = 1'b0, ce2 = 1'b0;
   logic [31:0] vals;
   logic [23:0] vals2;
   logic valid, err, busy, valid2, err2, busy2;
   logic [7:0] fcnt, fcnt2;

   int tests = 0, fails = 0;
   int nv = 0, ne = 0, nv2 = 0, ne2 = 0, coll = 0;
   int v0, e0;
   logic [31:0] mvals;
   int mcnt;

   always #5 clk = ~clk;

   eq_spi_rx dut (
      .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ce(ce),
      .eq_vals(vals), .eq_valid(valid), .frame_err(err), .busy(busy), .frame_cnt(fcnt)
   );

   eq_spi_rx #(.NBANDS(2), .BAND_W(12)) dut2 (
      .clk(clk), .reset(reset), .sck(sck2), .sdi(sdi2), .ce(ce2),
      .eq_vals(vals2), .eq_valid(valid2), .frame_err(err2), .busy(busy2), .frame_cnt(fcnt2)
   );

   always @(negedge clk) begin
      if (valid) nv++;
      if (err) ne++;
      if (valid2) nv2++;
      if (err2) ne2++;
      if ((valid && err) || (valid2 && err2)) coll++;
   end

   typedef struct {
      int          n;
      logic [63:0] bits;
      logic [31:0] vals;
      int          dv;
      int          de;
      logic [7:0]  cnt;
   } vec_t;

   task automatic wt(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic pins(input bit w, input logic s, input logic d, input logic c);
      if (w) begin sck2 = s; sdi2 = d; ce2 = c; end
      else begin sck = s; sdi = d; ce = c; end
   endtask

   task automatic send_bits(input bit w, input int n, input logic [63:0] bits);
      for (int i = n - 1; i >= 0; i--) begin
         pins(w, 1'b0, bits[i], 1'b1);
         wt(3);
         pins(w, 1'b1, bits[i], 1'b1);
         wt(3);
      end
      pins(w, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic frame(input bit w, input int n, input logic [63:0] bits);
      v0 = w ? nv2 : nv;
      e0 = w ? ne2 : ne;
      pins(w, 1'b0, 1'b0, 1'b1);
      wt(4);
      send_bits(w, n, bits);
      wt(3);
      pins(w, 1'b0, 1'b0, 1'b0);
      wt(8);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wt(3);
      reset = 1'b0;
      mvals = '0;
      mcnt = 0;
   endtask

   vec_t tbl[5];

   initial begin
      tbl[0] = '{32, 64'hA1B2C3D4, 32'hA1B2C3D4, 1, 0, 8'd1};
      tbl[1] = '{31, 64'h7FFFFFFF, 32'hA1B2C3D4, 0, 1, 8'd1};
      tbl[2] = '{33, {31'd0, 32'h0F0F0F0F, 1'b1}, 32'hA1B2C3D4, 0, 1, 8'd1};
      tbl[3] = '{0, 64'h0, 32'hA1B2C3D4, 0, 1, 8'd1};
      tbl[4] = '{32, 64'h0F0F0F0F, 32'h0F0F0F0F, 1, 0, 8'd2};

      wt(3);
      chk("rst_vals", vals, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", fcnt, 0);
      do_reset();
      wt(4);

      for (int i = 0; i < 5; i++) begin
         frame(1'b0, tbl[i].n, tbl[i].bits);
         chk($sformatf("tbl%0d_vals", i), vals, tbl[i].vals);
         chk($sformatf("tbl%0d_npulse_valid", i), nv - v0, tbl[i].dv);
         chk($sformatf("tbl%0d_npulse_err", i), ne - e0, tbl[i].de);
         chk($sformatf("tbl%0d_cnt", i), fcnt, tbl[i].cnt);
         chk($sformatf("tbl%0d_busy_after", i), busy, 0);
         if (i == 0) begin
            chk("band3", vals[31:24], 8'hA1);
            chk("band0", vals[7:0], 8'hD4);
         end
      end
      mvals = 32'h0F0F0F0F;
      mcnt = 2;

      for (int i = 0; i < 20; i++) begin
         int n;
         logic [63:0] d;
         n = ($urandom_range(0, 2) != 0) ? 32 : int'($urandom_range(0, 34));
         d = {$urandom, $urandom};
         frame(1'b0, n, d);
         if (n == 32) begin
            mvals = d[31:0];
            mcnt = (mcnt + 1) % 256;
         end
         chk($sformatf("rnd%0d_vals", i), vals, mvals);
         chk($sformatf("rnd%0d_cnt", i), fcnt, mcnt);
         chk($sformatf("rnd%0d_valid", i), nv - v0, (n == 32) ? 1 : 0);
         chk($sformatf("rnd%0d_err", i), ne - e0, (n == 32) ? 0 : 1);
      end

      // reset in the middle of a frame discards it silently
      v0 = nv; e0 = ne;
      pins(1'b0, 1'b0, 1'b0, 1'b1);
      wt(4);
      send_bits(1'b0, 16, 64'hBEEF);
      reset = 1'b1;
      pins(1'b0, 1'b0, 1'b0, 1'b0);
      wt(3);
      chk("midrst_busy", busy, 0);
      reset = 1'b0;
      mvals = '0; mcnt = 0;
      wt(6);
      chk("midrst_vals", vals, 0);
      chk("midrst_cnt", fcnt, 0);
      chk("midrst_pulses", (nv - v0) + (ne - e0), 0);
      frame(1'b0, 32, 64'h12345678);
      chk("post_rst_vals", vals, 32'h12345678);
      chk("post_rst_cnt", fcnt, 1);

      // ce already high when reset releases
      reset = 1'b1;
      pins(1'b0, 1'b0, 1'b0, 1'b1);
      wt(3);
      reset = 1'b0;
      v0 = nv; e0 = ne;
      wt(4);
      chk("ce_hi_busy", busy, 1);
      send_bits(1'b0, 32, 64'h55AA33CC);
      wt(3);
      pins(1'b0, 1'b0, 1'b0, 1'b0);
      wt(8);
      chk("ce_hi_vals", vals, 32'h55AA33CC);
      chk("ce_hi_cnt", fcnt, 1);
      chk("ce_hi_valid", nv - v0, 1);

      // counter wrap
      do_reset();
      wt(4);
      begin
         int base;
         logic [31:0] last;
         base = nv;
         last = '0;
         for (int i = 0; i < 256; i++) begin
            last = $urandom;
            frame(1'b0, 32, {32'd0, last});
         end
         chk("wrap_pulses", nv - base, 256);
         chk("wrap_cnt", fcnt, 0);
         chk("wrap_vals", vals, last);
      end

      frame(1'b1, 24, 64'hABC123);
      chk("p2_vals", vals2, 24'hABC123);
      chk("p2_band1", vals2[23:12], 12'hABC);
      chk("p2_cnt", fcnt2, 1);
      chk("p2_valid", nv2 - v0, 1);
      chk("p2_err", ne2, 0);

      chk("no_both_pulses", coll, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
